osc_vector_sweeper: RTL and testbench



---
 rtl/osc_vector_sweeper.sv | 155 +++++++++++++++
 tb/tb_osc_vector_sweeper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_vector_sweeper.sv
// Exhaustive stimulus sweep for a feedback loop under test: per vector, settle, count
// synchronised probe toggles over a fixed window, and record which vectors oscillate.
module osc_vector_sweeper #(
  parameter int VEC_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 16,
  parameter int TOGGLE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_first,
  input  logic             probe_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             osc_found,
  output logic [VEC_W-1:0] osc_vec,
  output logic [VEC_W:0]   osc_count
);

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TOG_W   = $clog2(TOGGLE_THRESH + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_MAX     = TOG_W'(TOGGLE_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             probe_s_q;
  logic             prev_q;
  logic             stop_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TOG_W-1:0] tog_q;
  logic [TOG_W-1:0] tog_d;
  logic             osc_d;
  logic             last_vec_d;

  logic [VEC_W-1:0] vec_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic [VEC_W-1:0] osc_vec_q;
  logic [VEC_W:0]   osc_cnt_q;

  // Toggle count saturates so the counter stays just wide enough for the threshold.
  always_comb begin
    tog_d = tog_q;
    if ((probe_s_q != prev_q) && (tog_q != TOG_MAX)) begin
      tog_d = tog_q + TOG_W'(1);
    end
    osc_d      = (tog_q >= TOG_MAX);
    last_vec_d = &vec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b0;
      probe_s_q <= 1'b0;
      prev_q    <= 1'b0;
      stop_q    <= 1'b0;
      cnt_q     <= '0;
      tog_q     <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      osc_vec_q <= '0;
      osc_cnt_q <= '0;
    end else begin
      sync1_q   <= probe_in;
      probe_s_q <= sync1_q;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            stop_q    <= stop_on_first;
            vec_q     <= '0;
            found_q   <= 1'b0;
            osc_vec_q <= '0;
            osc_cnt_q <= '0;
            cnt_q     <= '0;
            tog_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            prev_q  <= probe_s_q;
            cnt_q   <= '0;
            state_q <= S_MEASURE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_MEASURE: begin
          tog_q  <= tog_d;
          prev_q <= probe_s_q;
          if (cnt_q == WINDOW_LAST) begin
            cnt_q   <= '0;
            state_q <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EVAL: begin
          tog_q <= '0;
          if (osc_d) begin
            osc_cnt_q <= osc_cnt_q + {{VEC_W{1'b0}}, 1'b1};
            if (!found_q) begin
              osc_vec_q <= vec_q;
              found_q   <= 1'b1;
            end
          end
          // The sweep never wraps: all-ones is the final vector.
          if (last_vec_d || (osc_d && stop_q)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + VEC_W'(1);
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign osc_found = found_q;
  assign osc_vec   = osc_vec_q;
  assign osc_count = osc_cnt_q;

endmodule

// File: tb/tb_osc_vector_sweeper.sv
// Directed bench for osc_vector_sweeper: probe patterns keyed to the current vector,
// with hand-derived sweep results and done timing (21 cycles per vector).
module tb_osc_vector_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop_on_first = 1'b0;
  logic       probe_in = 1'b0;
  logic [7:0] vec_out;
  logic       busy;
  logic       done;
  logic       osc_found;
  logic [7:0] osc_vec;
  logic [8:0] osc_count;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;
  int vcnt  = 0;
  int off;

  osc_vector_sweeper dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop_on_first(stop_on_first),
    .probe_in     (probe_in),
    .vec_out      (vec_out),
    .busy         (busy),
    .done         (done),
    .osc_found    (osc_found),
    .osc_vec      (osc_vec),
    .osc_count    (osc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Probe patterns: 0 tied low, 1 toggle while vec==0x2A, 2 toggle while vec>=0xF0,
  // 3 a single rising edge mid-window of vec 0x10.
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        1: if (vec_out == 8'h2A) probe_in = ~probe_in;
        2: if (vec_out >= 8'hF0) probe_in = ~probe_in;
        3: if (vec_out == 8'h10) begin
             if (vcnt == 8) probe_in = 1'b1;
             vcnt++;
           end
        default: probe_in = 1'b0;
      endcase
    end
  end

  task automatic set_mode(input int m);
    @(negedge clk);
    mode = m;
    vcnt = 0;
    probe_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic accept(input logic stop);
    @(negedge clk);
    stop_on_first = stop;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_vec", vec_out, 0);
    chk("accept_found", osc_found, 0);
    chk("accept_oscvec", osc_vec, 0);
    chk("accept_count", osc_count, 0);
  endtask

  // Returns the edge offset (after acceptance) at which done is first seen.
  task automatic run_to_done(input bit chk_steps, input bit poke_start, output int o_off);
    o_off = -1;
    for (int o = 1; o <= 6000; o++) begin
      @(posedge clk);
      #1;
      if (poke_start && o == 100) start = 1'b1;
      if (poke_start && o == 101) start = 1'b0;
      if (chk_steps && (o % 21 == 0) && o < 5376) chk("vec_step", vec_out, o / 21);
      if (done) begin
        o_off = o;
        break;
      end
    end
    if (o_off < 0) chk("done_timeout", done, 1);
  endtask

  task automatic after_done;
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int seen_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", vec_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", osc_found, 0);
    chk("rst_count", osc_count, 0);
    rst = 1'b0;

    // Quiet probe, full sweep, stray start while busy.
    set_mode(0);
    accept(1'b0);
    run_to_done(1'b1, 1'b1, off);
    chk("a_done_off", off, 5376);
    chk("a_busy_at_done", busy, 0);
    chk("a_vec_held", vec_out, 8'hFF);
    after_done();
    chk("a_found", osc_found, 0);
    chk("a_count", osc_count, 0);
    chk("a_oscvec", osc_vec, 0);

    // Single oscillating vector 0x2A.
    set_mode(1);
    accept(1'b0);
    run_to_done(1'b0, 1'b0, off);
    chk("b_done_off", off, 5376);
    after_done();
    chk("b_found", osc_found, 1);
    chk("b_oscvec", osc_vec, 8'h2A);
    chk("b_count", osc_count, 1);

    // Oscillation from 0xF0 upward, stop at first hit: done after EVAL of vec 240.
    set_mode(2);
    accept(1'b1);
    run_to_done(1'b0, 1'b0, off);
    chk("c_done_off", off, 241 * 21);
    chk("c_vec", vec_out, 8'hF0);
    chk("c_oscvec", osc_vec, 8'hF0);
    chk("c_count", osc_count, 1);
    after_done();
    chk("c_found_hold", osc_found, 1);

    // One probe edge inside the window of 0x10 is below threshold; restart clears results.
    set_mode(3);
    chk("d_found_before", osc_found, 1);
    accept(1'b0);
    run_to_done(1'b0, 1'b0, off);
    chk("d_done_off", off, 5376);
    chk("d_count", osc_count, 0);
    chk("d_found", osc_found, 0);
    after_done();

    // Reset in the middle of the measurement window of vector 0x40.
    set_mode(0);
    accept(1'b0);
    for (int o = 1; o <= 64 * 21 + 8; o++) begin
      @(posedge clk);
      #1;
    end
    chk("e_vec_pre_rst", vec_out, 8'h40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("e_rst_vec", vec_out, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_done", done, 0);
    seen_done = 0;
    for (int o = 0; o < 30; o++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    chk("e_no_done", seen_done, 0);
    chk("e_idle_busy", busy, 0);
    accept(1'b0);
    for (int o = 1; o <= 21; o++) begin
      @(posedge clk);
      #1;
    end
    chk("e_rerun_vec1", vec_out, 1);
    chk("e_rerun_busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
